axi_write_responder: RTL and testbench

- AXI3-style write-channel slave (responder); the other end of the CPU-side AXI write master.
- Accepts one write burst at a time on AW/W and drives a simple synchronous memory write port beat by beat.
- Returns a single B response per burst. Used as an on-chip RAM/peripheral endpoint and as the write-side slave model for master bring-up.

---
 rtl/axi_write_responder_pkg.sv | 19 +
 rtl/axi_write_responder_if.sv | 56 +++++
 rtl/axi_burst_addr_gen.sv | 30 +++
 rtl/axi_write_responder.sv | 123 ++++++++++++
 tb/tb_axi_write_responder.sv | 270 +++++++++++++++++++++++++++
 5 files changed

// File: rtl/axi_write_responder_pkg.sv
// Shared encodings for the AXI write responder: FSM states, BRESP and AWBURST codes.
// Any future read-side responder imports the same definitions.
package axi_write_responder_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_DATA = 2'd1,
        ST_RESP = 2'd2
    } state_t;

    localparam logic [1:0] BRESP_OKAY   = 2'b00;
    localparam logic [1:0] BRESP_SLVERR = 2'b10;

    localparam logic [1:0] BURST_FIXED = 2'b00;
    localparam logic [1:0] BURST_INCR  = 2'b01;
    localparam logic [1:0] BURST_WRAP  = 2'b10;
    localparam logic [1:0] BURST_RSVD  = 2'b11;

endpackage

// File: rtl/axi_write_responder_if.sv
// AXI3 write channels (AW/W/B) plus the beat-wide memory write port.
// The slave modport is the responder's view; master is the requesting side / memory model.
interface axi_write_responder_if #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32,
    parameter int ID_W   = 4
);
    logic [ID_W-1:0]     awid;
    logic [ADDR_W-1:0]   awaddr;
    logic [3:0]          awlen;
    logic [2:0]          awsize;
    logic [1:0]          awburst;
    logic                awvalid;
    logic                awready;

    logic [ID_W-1:0]     wid;
    logic [DATA_W-1:0]   wdata;
    logic [DATA_W/8-1:0] wstrb;
    logic                wlast;
    logic                wvalid;
    logic                wready;

    logic [ID_W-1:0]     bid;
    logic [1:0]          bresp;
    logic                bvalid;
    logic                bready;

    logic                mem_we;
    logic [ADDR_W-1:0]   mem_addr;
    logic [DATA_W-1:0]   mem_wdata;
    logic [DATA_W/8-1:0] mem_wstrb;
    logic                mem_ready;

    modport slave (
        input  awid, awaddr, awlen, awsize, awburst, awvalid,
        output awready,
        input  wid, wdata, wstrb, wlast, wvalid,
        output wready,
        output bid, bresp, bvalid,
        input  bready,
        output mem_we, mem_addr, mem_wdata, mem_wstrb,
        input  mem_ready
    );

    modport master (
        output awid, awaddr, awlen, awsize, awburst, awvalid,
        input  awready,
        output wid, wdata, wstrb, wlast, wvalid,
        input  wready,
        input  bid, bresp, bvalid,
        output bready,
        input  mem_we, mem_addr, mem_wdata, mem_wstrb,
        output mem_ready
    );

endinterface

// File: rtl/axi_burst_addr_gen.sv
// Combinational AXI beat-address stepper: gives the address of the next beat.
// WRAP and reserved burst types hold the address; callers flag those as errors.
module axi_burst_addr_gen
    import axi_write_responder_pkg::*;
#(
    parameter int ADDR_W = 32
) (
    input  logic [ADDR_W-1:0] i_addr,
    input  logic [2:0]        i_size,
    input  logic [1:0]        i_burst,
    input  logic              i_advance,
    output logic [ADDR_W-1:0] o_next_addr
);

    logic [ADDR_W-1:0] w_step;

    assign w_step = ADDR_W'(1) << i_size;

    always_comb begin
        o_next_addr = i_addr;
        if (i_advance) begin
            case (i_burst)
                BURST_INCR:  o_next_addr = i_addr + w_step;
                BURST_FIXED: o_next_addr = i_addr;
                default:     o_next_addr = i_addr;
            endcase
        end
    end

endmodule

// File: rtl/axi_write_responder.sv
// Single-outstanding AXI3 write slave: takes one AW/W burst, writes it beat by beat
// to a simple memory port, then returns one B response (SLVERR if anything was off).
module axi_write_responder
    import axi_write_responder_pkg::*;
#(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32,
    parameter int ID_W   = 4
) (
    input  logic                   clk,
    input  logic                   reset,
    axi_write_responder_if.slave   bus
);

    localparam int STRB_W   = DATA_W / 8;
    localparam int MAX_SIZE = $clog2(STRB_W);

    state_t            r_state;
    state_t            w_state_next;
    logic              r_awready;
    logic [ID_W-1:0]   r_id;
    logic [ADDR_W-1:0] r_addr;
    logic [3:0]        r_len;
    logic [2:0]        r_size;
    logic [1:0]        r_burst;
    logic [3:0]        r_beat_cnt;
    logic              r_err;

    logic              w_aw_hs;
    logic              w_aw_err;
    logic              w_beat;
    logic              w_last_beat;
    logic              w_id_bad;
    logic              w_wlast_bad;
    logic              w_beat_err;
    logic              w_wready;
    logic              w_bvalid;
    logic [ADDR_W-1:0] w_next_addr;

    // awready only ever comes from a register, so it stays low until the first edge after reset
    assign w_aw_hs  = bus.awvalid && r_awready;
    assign w_aw_err = (bus.awburst == BURST_WRAP) || (bus.awburst == BURST_RSVD) ||
                      (bus.awsize > 3'(MAX_SIZE));

    assign w_last_beat = (r_beat_cnt == r_len);
    assign w_id_bad    = (bus.wid != r_id);
    assign w_wlast_bad = (bus.wlast != w_last_beat);
    assign w_beat      = w_wready && bus.wvalid;
    // A wid mismatch suppresses its own beat; a wlast mismatch only affects later beats
    assign w_beat_err  = r_err || w_id_bad;

    axi_burst_addr_gen #(
        .ADDR_W (ADDR_W)
    ) u_addr_gen (
        .i_addr      (r_addr),
        .i_size      (r_size),
        .i_burst     (r_burst),
        .i_advance   (w_beat),
        .o_next_addr (w_next_addr)
    );

    always_comb begin
        w_state_next = r_state;
        w_wready     = 1'b0;
        w_bvalid     = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (w_aw_hs) w_state_next = ST_DATA;
            end
            ST_DATA: begin
                w_wready = bus.mem_ready;
                if (bus.wvalid && bus.mem_ready && w_last_beat) w_state_next = ST_RESP;
            end
            ST_RESP: begin
                w_bvalid = 1'b1;
                if (bus.bready) w_state_next = ST_IDLE;
            end
            default: w_state_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state    <= ST_IDLE;
            r_awready  <= 1'b0;
            r_id       <= '0;
            r_addr     <= '0;
            r_len      <= '0;
            r_size     <= '0;
            r_burst    <= '0;
            r_beat_cnt <= '0;
            r_err      <= 1'b0;
        end else begin
            r_state   <= w_state_next;
            r_awready <= (w_state_next == ST_IDLE);
            if (w_aw_hs) begin
                r_id       <= bus.awid;
                r_addr     <= bus.awaddr;
                r_len      <= bus.awlen;
                r_size     <= bus.awsize;
                r_burst    <= bus.awburst;
                r_beat_cnt <= '0;
                r_err      <= w_aw_err;
            end else if (w_beat) begin
                r_beat_cnt <= r_beat_cnt + 4'd1;
                r_addr     <= w_next_addr;
                if (w_id_bad || w_wlast_bad) r_err <= 1'b1;
            end
        end
    end

    assign bus.awready   = r_awready;
    assign bus.wready    = w_wready;
    assign bus.bvalid    = w_bvalid;
    assign bus.bid       = w_bvalid ? r_id : '0;
    assign bus.bresp     = (w_bvalid && r_err) ? BRESP_SLVERR : BRESP_OKAY;

    assign bus.mem_we    = w_beat && !w_beat_err;
    assign bus.mem_addr  = r_addr;
    assign bus.mem_wdata = bus.wdata;
    assign bus.mem_wstrb = w_beat_err ? '0 : bus.wstrb;

endmodule

// File: tb/tb_axi_write_responder.sv
// Directed bench for axi_write_responder: scripted AW/W/B sequences with hand-computed
// expected memory writes and responses, checked by immediate assertions.
module tb_axi_write_responder;
    import axi_write_responder_pkg::*;

    logic clk = 1'b0;
    logic reset = 1'b0;
    int   vectors = 0;
    int   miscompares = 0;

    logic [31:0] q_addr[$];
    logic [31:0] q_data[$];
    logic [3:0]  q_strb[$];

    always #5 clk = ~clk;

    axi_write_responder_if #(.ADDR_W(32), .DATA_W(32), .ID_W(4)) bus ();

    axi_write_responder #(
        .ADDR_W (32),
        .DATA_W (32),
        .ID_W   (4)
    ) u_dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always @(posedge clk) begin
        if (bus.mem_we === 1'b1) begin
            q_addr.push_back(bus.mem_addr);
            q_data.push_back(bus.mem_wdata);
            q_strb.push_back(bus.mem_wstrb);
        end
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic do_aw(input logic [3:0] id, input logic [31:0] addr, input logic [3:0] len,
                         input logic [2:0] size, input logic [1:0] burst);
        bit got = 0;
        @(negedge clk);
        bus.awid = id; bus.awaddr = addr; bus.awlen = len;
        bus.awsize = size; bus.awburst = burst; bus.awvalid = 1'b1;
        for (int i = 0; i < 20; i++) begin
            #1;
            if (bus.awready === 1'b1) begin got = 1; break; end
            @(negedge clk);
        end
        chk("aw_handshake", 64'(got), 64'd1);
        @(negedge clk);
        bus.awvalid = 1'b0;
    endtask

    task automatic w_beat(input logic [3:0] id, input logic [31:0] data, input logic [3:0] strb,
                          input logic last);
        bit got = 0;
        bus.wid = id; bus.wdata = data; bus.wstrb = strb; bus.wlast = last; bus.wvalid = 1'b1;
        for (int i = 0; i < 20; i++) begin
            #1;
            if (bus.wready === 1'b1) begin got = 1; break; end
            @(negedge clk);
        end
        chk("w_handshake", 64'(got), 64'd1);
        @(negedge clk);
        bus.wvalid = 1'b0;
    endtask

    task automatic do_b(input logic [3:0] id, input logic [1:0] resp);
        bit got = 0;
        bus.bready = 1'b1;
        for (int i = 0; i < 20; i++) begin
            if (bus.bvalid === 1'b1) begin got = 1; break; end
            @(negedge clk);
            #1;
        end
        chk("b_handshake", 64'(got), 64'd1);
        chk("bid", 64'(bus.bid), 64'(id));
        chk("bresp", 64'(bus.bresp), 64'(resp));
        @(posedge clk);
        @(negedge clk);
        bus.bready = 1'b0;
        #1;
        chk("bvalid_drop", 64'(bus.bvalid), 64'd0);
        chk("awready_after_b", 64'(bus.awready), 64'd1);
    endtask

    // Expect n writes at base + i*step carrying data dbase + i with full strobes
    task automatic chk_writes(input string tag, input int n, input logic [31:0] base,
                              input logic [31:0] step, input logic [31:0] dbase);
        chk({tag, "_count"}, 64'(q_addr.size()), 64'(n));
        for (int i = 0; i < n && i < q_addr.size(); i++) begin
            chk({tag, "_addr"}, 64'(q_addr[i]), 64'(base + step * 32'(i)));
            chk({tag, "_data"}, 64'(q_data[i]), 64'(dbase + 32'(i)));
            chk({tag, "_strb"}, 64'(q_strb[i]), 64'hF);
        end
        q_addr.delete(); q_data.delete(); q_strb.delete();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, observed timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        bus.awid = '0; bus.awaddr = '0; bus.awlen = '0; bus.awsize = '0; bus.awburst = '0;
        bus.awvalid = 1'b0; bus.wid = '0; bus.wdata = '0; bus.wstrb = '0; bus.wlast = 1'b0;
        bus.wvalid = 1'b0; bus.bready = 1'b0; bus.mem_ready = 1'b1;

        // Reset values, awready rising only at the first edge after release
        repeat (3) @(negedge clk);
        #1;
        chk("rst_awready", 64'(bus.awready), 64'd0);
        chk("rst_wready", 64'(bus.wready), 64'd0);
        chk("rst_bvalid", 64'(bus.bvalid), 64'd0);
        chk("rst_bid", 64'(bus.bid), 64'd0);
        chk("rst_bresp", 64'(bus.bresp), 64'd0);
        chk("rst_mem_we", 64'(bus.mem_we), 64'd0);
        reset = 1'b1;
        #1;
        chk("rel_awready_pre_edge", 64'(bus.awready), 64'd0);
        @(negedge clk);
        #1;
        chk("rel_awready_post_edge", 64'(bus.awready), 64'd1);

        // Single beat INCR
        do_aw(4'h5, 32'h0000_1000, 4'd0, 3'd2, BURST_INCR);
        #1;
        chk("single_wready", 64'(bus.wready), 64'd1);
        chk("single_awready_low", 64'(bus.awready), 64'd0);
        w_beat(4'h5, 32'hDEAD_BEEF, 4'hF, 1'b1);
        #1;
        chk("single_bvalid_next", 64'(bus.bvalid), 64'd1);
        do_b(4'h5, BRESP_OKAY);
        chk_writes("single", 1, 32'h1000, 32'd4, 32'hDEAD_BEEF);

        // INCR len 3 with a two-cycle mem_ready stall before beat 2
        do_aw(4'h3, 32'h0000_0020, 4'd3, 3'd2, BURST_INCR);
        w_beat(4'h3, 32'h1111_0000, 4'hF, 1'b0);
        w_beat(4'h3, 32'h1111_0001, 4'hF, 1'b0);
        bus.mem_ready = 1'b0;
        bus.wid = 4'h3; bus.wdata = 32'h1111_0002; bus.wstrb = 4'hF; bus.wlast = 1'b0;
        bus.wvalid = 1'b1;
        for (int i = 0; i < 2; i++) begin
            #1;
            chk("stall_wready", 64'(bus.wready), 64'd0);
            chk("stall_mem_we", 64'(bus.mem_we), 64'd0);
            @(negedge clk);
        end
        chk("stall_no_extra_write", 64'(q_addr.size()), 64'd2);
        bus.mem_ready = 1'b1;
        w_beat(4'h3, 32'h1111_0002, 4'hF, 1'b0);
        w_beat(4'h3, 32'h1111_0003, 4'hF, 1'b1);
        do_b(4'h3, BRESP_OKAY);
        chk_writes("incr", 4, 32'h20, 32'd4, 32'h1111_0000);

        // FIXED len 2: all beats to the same address
        do_aw(4'h7, 32'h0000_0040, 4'd2, 3'd2, BURST_FIXED);
        w_beat(4'h7, 32'h2222_0000, 4'hF, 1'b0);
        w_beat(4'h7, 32'h2222_0001, 4'hF, 1'b0);
        w_beat(4'h7, 32'h2222_0002, 4'hF, 1'b1);
        do_b(4'h7, BRESP_OKAY);
        chk_writes("fixed", 3, 32'h40, 32'd0, 32'h2222_0000);

        // WRAP burst is rejected: no writes, SLVERR
        do_aw(4'h1, 32'h0000_0080, 4'd1, 3'd2, BURST_WRAP);
        w_beat(4'h1, 32'h3333_0000, 4'hF, 1'b0);
        w_beat(4'h1, 32'h3333_0001, 4'hF, 1'b1);
        do_b(4'h1, BRESP_SLVERR);
        chk_writes("wrap", 0, 32'h0, 32'd0, 32'h0);

        // awsize 3 exceeds the 4-byte bus
        do_aw(4'h8, 32'h0000_0090, 4'd0, 3'd3, BURST_INCR);
        w_beat(4'h8, 32'h4444_0000, 4'hF, 1'b1);
        do_b(4'h8, BRESP_SLVERR);
        chk_writes("size3", 0, 32'h0, 32'd0, 32'h0);

        // Wrong wid on beat 0 poisons the whole burst
        do_aw(4'h2, 32'h0000_00A0, 4'd1, 3'd2, BURST_INCR);
        bus.wid = 4'h9; bus.wdata = 32'h5555_0000; bus.wstrb = 4'hF; bus.wlast = 1'b0;
        bus.wvalid = 1'b1;
        #1;
        chk("badid_mem_we", 64'(bus.mem_we), 64'd0);
        chk("badid_mem_wstrb", 64'(bus.mem_wstrb), 64'd0);
        w_beat(4'h9, 32'h5555_0000, 4'hF, 1'b0);
        w_beat(4'h2, 32'h5555_0001, 4'hF, 1'b1);
        do_b(4'h2, BRESP_SLVERR);
        chk_writes("badid", 0, 32'h0, 32'd0, 32'h0);

        // Early wlast on beat 1 of 3: beats 0 and 1 written, beat 2 dropped
        do_aw(4'h4, 32'h0000_0100, 4'd2, 3'd2, BURST_INCR);
        w_beat(4'h4, 32'h6666_0000, 4'hF, 1'b0);
        w_beat(4'h4, 32'h6666_0001, 4'hF, 1'b1);
        w_beat(4'h4, 32'h6666_0002, 4'hF, 1'b1);
        do_b(4'h4, BRESP_SLVERR);
        chk_writes("early_wlast", 2, 32'h100, 32'd4, 32'h6666_0000);

        // W presented before AW waits without acceptance
        @(negedge clk);
        bus.wid = 4'h6; bus.wdata = 32'h7777_0000; bus.wstrb = 4'hF; bus.wlast = 1'b1;
        bus.wvalid = 1'b1;
        for (int i = 0; i < 3; i++) begin
            #1;
            chk("w_first_wready", 64'(bus.wready), 64'd0);
            @(negedge clk);
        end
        chk("w_first_no_write", 64'(q_addr.size()), 64'd0);
        do_aw(4'h6, 32'h0000_0200, 4'd0, 3'd2, BURST_INCR);
        w_beat(4'h6, 32'h7777_0000, 4'hF, 1'b1);
        do_b(4'h6, BRESP_OKAY);
        chk_writes("w_first", 1, 32'h200, 32'd4, 32'h7777_0000);

        // bready held low: response stays stable and no new AW is taken
        do_aw(4'hA, 32'h0000_0300, 4'd0, 3'd2, BURST_INCR);
        w_beat(4'hA, 32'h8888_0000, 4'hF, 1'b1);
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            #1;
            chk("bhold_bvalid", 64'(bus.bvalid), 64'd1);
            chk("bhold_bid", 64'(bus.bid), 64'hA);
            chk("bhold_bresp", 64'(bus.bresp), 64'(BRESP_OKAY));
            chk("bhold_awready", 64'(bus.awready), 64'd0);
        end
        do_b(4'hA, BRESP_OKAY);
        chk_writes("bhold", 1, 32'h300, 32'd4, 32'h8888_0000);

        // Reset during beat 2 of an 8-beat burst aborts it without a response
        do_aw(4'hB, 32'h0000_0400, 4'd7, 3'd2, BURST_INCR);
        w_beat(4'hB, 32'h9999_0000, 4'hF, 1'b0);
        w_beat(4'hB, 32'h9999_0001, 4'hF, 1'b0);
        bus.wid = 4'hB; bus.wdata = 32'h9999_0002; bus.wstrb = 4'hF; bus.wlast = 1'b0;
        bus.wvalid = 1'b1;
        #1;
        chk("abort_pre_mem_we", 64'(bus.mem_we), 64'd1);
        reset = 1'b0;
        #1;
        chk("abort_mem_we", 64'(bus.mem_we), 64'd0);
        chk("abort_wready", 64'(bus.wready), 64'd0);
        chk("abort_awready", 64'(bus.awready), 64'd0);
        chk("abort_bvalid", 64'(bus.bvalid), 64'd0);
        bus.wvalid = 1'b0;
        @(negedge clk);
        @(negedge clk);
        reset = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            #1;
            chk("abort_no_b", 64'(bus.bvalid), 64'd0);
            chk("abort_idle_awready", 64'(bus.awready), 64'd1);
        end
        chk_writes("abort", 2, 32'h400, 32'd4, 32'h9999_0000);

        do_aw(4'hC, 32'h0000_0500, 4'd1, 3'd2, BURST_INCR);
        w_beat(4'hC, 32'hAAAA_0000, 4'hF, 1'b0);
        w_beat(4'hC, 32'hAAAA_0001, 4'hF, 1'b1);
        do_b(4'hC, BRESP_OKAY);
        chk_writes("post_abort", 2, 32'h500, 32'd4, 32'hAAAA_0000);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
